// File: rtl/register_file.sv
// ============================================================================
// register_file : NUM_REGS x DATA_WIDTH operand store, 2 async read / 1 sync write port
// Optional macro REGFILE_WRITE_BYPASS_EN forwards write_data to a matching read port.
// Revision 1.0
// ============================================================================
`default_nettype none

module register_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] read_register_port_0,
   input  logic [ADDR_WIDTH-1:0] read_register_port_1,
   input  logic [ADDR_WIDTH-1:0] write_register,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  write_enable,
   output logic [DATA_WIDTH-1:0] read_data_port_0,
   output logic [DATA_WIDTH-1:0] read_data_port_1
);

   localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
   localparam int NUM_PORTS = 2;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic [ADDR_WIDTH-1:0] read_addr [NUM_PORTS];
   logic [DATA_WIDTH-1:0] read_data [NUM_PORTS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_enable) begin
         regs[write_register] <= write_data;
      end
   end

   assign read_addr[0] = read_register_port_0;
   assign read_addr[1] = read_register_port_1;

   // Outputs are forced to zero under reset so forwarding cannot leak write_data.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_read_port
      always_comb begin
         read_data[p] = regs[read_addr[p]];
`ifdef REGFILE_WRITE_BYPASS_EN
         if (write_enable && (read_addr[p] == write_register)) begin
            read_data[p] = write_data;
         end
`endif
         if (!rst_n) begin
            read_data[p] = '0;
         end
      end
   end

   assign read_data_port_0 = read_data[0];
   assign read_data_port_1 = read_data[1];

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// tb_register_file : scoreboard-driven bench for register_file
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_register_file;

   localparam int DW = 32;
   localparam int AW = 2;
   localparam int NR = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] rd0, rd1, wr;
   logic [DW-1:0] wdata;
   logic          we;
   logic [DW-1:0] q0, q1;

   logic [DW-1:0] mdl [NR];
   logic [DW-1:0] exp_q [$];
   int            n_checks = 0;
   int            n_fail   = 0;

   register_file #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .read_register_port_0 (rd0),
      .read_register_port_1 (rd1),
      .write_register       (wr),
      .write_data           (wdata),
      .write_enable         (we),
      .read_data_port_0     (q0),
      .read_data_port_1     (q1)
   );

   always #5 clk = ~clk;

   // Performs one enabled edge; model follows only if reset is released.
   task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr    = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      if (rst_n) mdl[a] = d;
   endtask

   task automatic test_reset();
      logic [DW-1:0] e;
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      #3;
      for (int i = 0; i < NR; i++) begin
         rd0 = AW'(i);
         rd1 = AW'(NR - 1 - i);
         exp_q.push_back('0);
         exp_q.push_back('0);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (q0 !== e) begin
            n_fail++;
            $display("FAIL reset_p0 idx=%0d got=%h exp=%h", i, q0, e);
         end
         e = exp_q.pop_front();
         n_checks++;
         if (q1 !== e) begin
            n_fail++;
            $display("FAIL reset_p1 idx=%0d got=%h exp=%h", NR - 1 - i, q1, e);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_readback();
      logic [DW-1:0] e;
      write_reg(2'd0, 32'd21);
      write_reg(2'd1, 32'd42);
      write_reg(2'd2, 32'd84);
      write_reg(2'd3, 32'd168);
      for (int i = 0; i < NR; i++) begin
         rd0 = AW'(i);
         rd1 = AW'(NR - 1 - i);
         exp_q.push_back(mdl[i]);
         exp_q.push_back(mdl[NR - 1 - i]);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (q0 !== e) begin
            n_fail++;
            $display("FAIL readback_p0 idx=%0d got=%0d exp=%0d", i, q0, e);
         end
         e = exp_q.pop_front();
         n_checks++;
         if (q1 !== e) begin
            n_fail++;
            $display("FAIL readback_p1 idx=%0d got=%0d exp=%0d", NR - 1 - i, q1, e);
         end
      end
   endtask

   task automatic test_write_disabled();
      logic [DW-1:0] e;
      wr    = 2'd2;
      wdata = 32'd99;
      we    = 1'b0;
      rd0   = 2'd2;
      rd1   = 2'd2;
      repeat (3) @(posedge clk);
      #1;
      exp_q.push_back(32'd84);
      exp_q.push_back(32'd84);
      e = exp_q.pop_front();
      n_checks++;
      if (q0 !== e) begin
         n_fail++;
         $display("FAIL wr_disabled_p0 got=%0d exp=%0d", q0, e);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (q1 !== e) begin
         n_fail++;
         $display("FAIL wr_disabled_p1 got=%0d exp=%0d", q1, e);
      end
   endtask

   task automatic test_collision();
      logic [DW-1:0] e;
      rd0   = 2'd1;
      rd1   = 2'd0;
      wr    = 2'd1;
      wdata = 32'd7;
      we    = 1'b1;
`ifdef REGFILE_WRITE_BYPASS_EN
      exp_q.push_back(32'd7);
`else
      exp_q.push_back(32'd42);
`endif
      exp_q.push_back(32'd21);
      #2;
      e = exp_q.pop_front();
      n_checks++;
      if (q0 !== e) begin
         n_fail++;
         $display("FAIL collision_before got=%0d exp=%0d", q0, e);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (q1 !== e) begin
         n_fail++;
         $display("FAIL collision_other_port got=%0d exp=%0d", q1, e);
      end
      @(posedge clk);
      #1;
      we      = 1'b0;
      mdl[1]  = 32'd7;
      exp_q.push_back(32'd7);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (q0 !== e) begin
         n_fail++;
         $display("FAIL collision_after got=%0d exp=%0d", q0, e);
      end
   endtask

   task automatic test_async_reset();
      logic [DW-1:0] e;
      wr    = 2'd3;
      wdata = 32'd55;
      we    = 1'b1;
      rd0   = 2'd3;
      rd1   = 2'd1;
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (q0 !== e) begin
         n_fail++;
         $display("FAIL async_reset_p0 got=%h exp=%h", q0, e);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (q1 !== e) begin
         n_fail++;
         $display("FAIL async_reset_p1 got=%h exp=%h", q1, e);
      end
      // Hold reset across an enabled edge; nothing may be written.
      @(posedge clk);
      #1;
      we = 1'b0;
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < NR; i++) begin
         rd0 = AW'(i);
         exp_q.push_back(mdl[i]);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (q0 !== e) begin
            n_fail++;
            $display("FAIL reset_no_write idx=%0d got=%h exp=%h", i, q0, e);
         end
      end
      write_reg(2'd0, 32'd5);
      rd0 = 2'd0;
      rd1 = 2'd3;
      exp_q.push_back(mdl[0]);
      exp_q.push_back(mdl[3]);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (q0 !== e) begin
         n_fail++;
         $display("FAIL first_write_after_reset got=%h exp=%h", q0, e);
      end
      e = exp_q.pop_front();
      n_checks++;
      if (q1 !== e) begin
         n_fail++;
         $display("FAIL untouched_after_reset got=%h exp=%h", q1, e);
      end
   endtask

   task automatic test_dual_port();
      logic [DW-1:0] e;
      write_reg(2'd3, 32'd168);
      write_reg(2'd2, 32'hFFFF_FFFF);
      for (int i = 2; i < NR; i++) begin
         rd0 = AW'(i);
         rd1 = AW'(i);
         exp_q.push_back(mdl[i]);
         exp_q.push_back(mdl[i]);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (q0 !== e) begin
            n_fail++;
            $display("FAIL dual_p0 idx=%0d got=%h exp=%h", i, q0, e);
         end
         e = exp_q.pop_front();
         n_checks++;
         if (q1 !== e) begin
            n_fail++;
            $display("FAIL dual_p1 idx=%0d got=%h exp=%h", i, q1, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] e;
      logic [DW-1:0] v;
      we = 1'b1;
      for (int i = 0; i < NR; i++) begin
         v     = $urandom;
         wr    = AW'(i);
         wdata = v;
         @(posedge clk);
         #1;
         mdl[i] = v;
      end
      we = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rd0 = AW'(i);
         rd1 = AW'((i + 1) % NR);
         exp_q.push_back(mdl[i]);
         exp_q.push_back(mdl[(i + 1) % NR]);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (q0 !== e) begin
            n_fail++;
            $display("FAIL b2b_p0 idx=%0d got=%h exp=%h", i, q0, e);
         end
         e = exp_q.pop_front();
         n_checks++;
         if (q1 !== e) begin
            n_fail++;
            $display("FAIL b2b_p1 idx=%0d got=%h exp=%h", (i + 1) % NR, q1, e);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rd0   = '0;
      rd1   = '0;
      wr    = '0;
      wdata = '0;
      we    = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_write_readback();
      test_write_disabled();
      test_collision();
      @(posedge clk);
      #1;
      test_async_reset();
      test_dual_port();
      test_back_to_back();
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
